// File: rtl/parking_pkg.sv
// Shared definitions for the parking lot occupancy blocks.
package parking_pkg;
  localparam int NUM_SLOTS  = 8;
  localparam int SLOT_W     = 3;
  localparam int GATE_CNT_W = 4;

  typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} state_t;

  // Free slots remaining in an occupancy mask (0..NUM_SLOTS).
  function automatic logic [3:0] free_slots(input logic [NUM_SLOTS-1:0] occ);
    logic [3:0] n;
    n = 4'(NUM_SLOTS);
    for (int i = 0; i < NUM_SLOTS; i++) n = n - {3'b000, occ[i]};
    return n;
  endfunction
endpackage

// File: rtl/slot_finder.sv
// Combinational priority encoder: index of the lowest free (zero) slot.
module slot_finder import parking_pkg::*; (
  input  logic [NUM_SLOTS-1:0] occupancy,
  output logic [SLOT_W-1:0]    index,
  output logic                 found
);
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occupancy[i]) begin
        index = SLOT_W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/parking_slot_manager.sv
// Slot allocator/releaser for the 8-slot lot with a timed gate that blocks
// further requests while open.
module parking_slot_manager import parking_pkg::*; #(
  parameter int GATE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enter_req,
  input  logic                 exit_req,
  input  logic [NUM_SLOTS-1:0] exit_location,
  output logic                 entry_grant,
  output logic [SLOT_W-1:0]    entry_slot,
  output logic                 entry_denied,
  output logic                 exit_error,
  output logic [NUM_SLOTS-1:0] occupancy,
  output logic [3:0]           free_count,
  output logic                 full,
  output logic                 empty,
  output logic                 gate_open,
  output logic                 busy
);
  localparam logic [GATE_CNT_W-1:0] GATE_LOAD = GATE_CNT_W'(GATE_CYCLES - 1);

  state_t                 state;
  logic [GATE_CNT_W-1:0]  gate_cnt;
  logic [SLOT_W-1:0]      free_idx;
  logic                   free_found;
  logic                   exit_ok;
  logic                   entry_ok;
  logic [NUM_SLOTS-1:0]   occ_next;

  slot_finder u_finder (
    .occupancy (occupancy),
    .index     (free_idx),
    .found     (free_found)
  );

  // Both decisions use the pre-update mask, so a slot being freed this cycle
  // is still seen as occupied by the finder. An unknown mask falls to invalid.
  always_comb begin
    exit_ok  = 1'b0;
    entry_ok = 1'b0;
    if (exit_req && $onehot(exit_location) && ((exit_location & occupancy) != '0))
      exit_ok = 1'b1;
    if (enter_req && free_found)
      entry_ok = 1'b1;
    occ_next = occupancy;
    if (exit_ok)  occ_next = occ_next & ~exit_location;
    if (entry_ok) occ_next[free_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      gate_cnt     <= '0;
      occupancy    <= '0;
      free_count   <= 4'(NUM_SLOTS);
      full         <= 1'b0;
      empty        <= 1'b1;
      entry_slot   <= '0;
      entry_grant  <= 1'b0;
      entry_denied <= 1'b0;
      exit_error   <= 1'b0;
      gate_open    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      entry_grant  <= 1'b0;
      entry_denied <= 1'b0;
      exit_error   <= 1'b0;
      case (state)
        IDLE: begin
          if (entry_ok) begin
            entry_grant <= 1'b1;
            entry_slot  <= free_idx;
          end else if (enter_req) begin
            entry_denied <= 1'b1;
          end
          if (exit_req && !exit_ok) exit_error <= 1'b1;
          occupancy  <= occ_next;
          free_count <= free_slots(occ_next);
          full       <= &occ_next;
          empty      <= ~|occ_next;
          if (entry_ok || exit_ok) begin
            state     <= OPEN;
            gate_cnt  <= GATE_LOAD;
            gate_open <= 1'b1;
            busy      <= 1'b1;
          end
        end
        OPEN: begin
          if (gate_cnt == '0) begin
            state     <= IDLE;
            gate_open <= 1'b0;
            busy      <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          gate_open <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_parking_slot_manager.sv
// Scoreboard bench for parking_slot_manager: directed scenarios plus random
// traffic checked against an array-level model of the lot.
module tb_parking_slot_manager;
  localparam int G = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enter_req = 1'b0;
  logic       exit_req = 1'b0;
  logic [7:0] exit_location = 8'h00;
  logic       entry_grant, entry_denied, exit_error, full, empty, gate_open, busy;
  logic [2:0] entry_slot;
  logic [7:0] occupancy;
  logic [3:0] free_count;

  parking_slot_manager #(.GATE_CYCLES(G)) dut (
    .clk(clk), .reset(reset), .enter_req(enter_req), .exit_req(exit_req),
    .exit_location(exit_location), .entry_grant(entry_grant), .entry_slot(entry_slot),
    .entry_denied(entry_denied), .exit_error(exit_error), .occupancy(occupancy),
    .free_count(free_count), .full(full), .empty(empty), .gate_open(gate_open), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       grant, denied, err;
    logic [2:0] slot;
    logic [7:0] occ;
    logic [3:0] free;
    logic       full, empty, gate;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  logic gate_prev = 1'b0;

  // reference model state
  logic [7:0] m_occ = 8'h00;
  logic [2:0] m_slot = 3'd0;
  int         open_until = 0;

  always @(posedge clk) edge_cnt++;

  // monitor: every pulse or gate rising edge is one response to compare
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (entry_grant || entry_denied || exit_error || (gate_open && !gate_prev))) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: grant=%b denied=%b err=%b gate=%b with nothing expected",
                 entry_grant, entry_denied, exit_error, gate_open);
      end else begin
        e = q.pop_front();
        if ({entry_grant, entry_denied, exit_error} !== {e.grant, e.denied, e.err}) begin
          errors++;
          $display("FAIL pulses: got g/d/e=%b%b%b want %b%b%b", entry_grant, entry_denied,
                   exit_error, e.grant, e.denied, e.err);
        end
        checks++;
        if ({entry_slot, occupancy, free_count, full, empty, gate_open} !==
            {e.slot, e.occ, e.free, e.full, e.empty, e.gate}) begin
          errors++;
          $display("FAIL state: got slot=%0d occ=%h free=%0d full=%b empty=%b gate=%b want slot=%0d occ=%h free=%0d full=%b empty=%b gate=%b",
                   entry_slot, occupancy, free_count, full, empty, gate_open,
                   e.slot, e.occ, e.free, e.full, e.empty, e.gate);
        end
      end
    end
    gate_prev = gate_open;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // s = clock edge number at which the DUT samples this request
  task automatic model(input logic en, input logic ex, input logic [7:0] m, input int s);
    exp_t e;
    logic vex;
    int idx;
    logic [7:0] nxt;
    if (!en && !ex) return;
    if (s < open_until) return;
    vex = ex && ($countones(m) == 1) && ((m & m_occ) != 8'h00);
    e.grant = 1'b0; e.denied = 1'b0; e.err = ex && !vex;
    idx = -1;
    for (int i = 0; i < 8; i++) if (!m_occ[i] && idx < 0) idx = i;
    nxt = m_occ;
    if (vex) nxt = nxt & ~m;
    if (en) begin
      if (idx >= 0) begin
        e.grant = 1'b1;
        nxt[idx] = 1'b1;
        m_slot = idx[2:0];
      end else e.denied = 1'b1;
    end
    m_occ   = nxt;
    e.slot  = m_slot;
    e.occ   = m_occ;
    e.free  = 4'(8 - $countones(m_occ));
    e.full  = (m_occ == 8'hFF);
    e.empty = (m_occ == 8'h00);
    e.gate  = e.grant || vex;
    if (e.gate) open_until = s + G + 1;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input logic en, input logic ex, input logic [7:0] m);
    enter_req = en; exit_req = ex; exit_location = m;
    model(en, ex, m, edge_cnt + 1);
    @(posedge clk); #1;
    enter_req = 1'b0; exit_req = 1'b0; exit_location = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    check("drained_before_reset", q.size(), 0);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    m_occ = 8'h00; m_slot = 3'd0; open_until = 0;
  endtask

  task automatic count_gate(input string name, input int cycles, input int want);
    int n;
    n = 0;
    repeat (cycles) begin @(negedge clk); if (gate_open) n++; end
    @(posedge clk); #1;
    check(name, n, want);
  endtask

  task automatic fill(input int n);
    repeat (n) begin issue(1'b1, 1'b0, 8'h00); idle(G); end
  endtask

  initial begin
    logic en, ex;
    logic [7:0] m;
    idle(2);
    check("reset_state",
          {entry_grant, entry_denied, exit_error, entry_slot, occupancy, free_count, full, empty, gate_open, busy},
          {1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0});
    reset = 1'b0;
    idle(1);

    // fill the lot, then one more arrival is denied without opening the gate
    fill(8);
    check("full_after_8", {full, free_count}, {1'b1, 4'd0});
    issue(1'b1, 1'b0, 8'h00);
    count_gate("gate_closed_on_deny", G + 2, 0);

    // release slot 2 from a full lot; gate open exactly G cycles; refill gets 2
    issue(1'b0, 1'b1, 8'h04);
    count_gate("gate_open_len", G + 3, G);
    issue(1'b1, 1'b0, 8'h00);
    idle(G);

    // simultaneous enter + exit from 8'h0F
    do_reset();
    fill(4);
    issue(1'b1, 1'b1, 8'h01);
    idle(G);
    check("simul_occ", {occupancy, free_count, entry_slot}, {8'h1E, 4'd4, 3'd4});

    // invalid exits from 8'h03
    do_reset();
    fill(2);
    issue(1'b0, 1'b1, 8'h00);
    issue(1'b0, 1'b1, 8'h06);
    issue(1'b0, 1'b1, 8'h10);
    count_gate("gate_closed_on_bad_exit", 3, 0);

    // requests during OPEN are ignored; the one right after busy falls is served
    issue(1'b1, 1'b0, 8'h00);
    check("busy_high", {busy, gate_open}, 2'b11);
    repeat (G) issue(1'b1, 1'b1, 8'h01);
    issue(1'b1, 1'b0, 8'h00);
    idle(G);
    check("after_busy_occ", occupancy, 8'h0F);

    // randomized traffic
    do_reset();
    for (int k = 0; k < 300; k++) begin
      en = 1'($urandom % 2);
      ex = 1'($urandom % 2);
      if (!en && !ex) en = 1'b1;
      m = ($urandom % 4 != 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      issue(en, ex, m);
      idle($urandom_range(0, G + 1));
    end

    // asynchronous reset mid-OPEN with occupancy 8'h55
    do_reset();
    fill(8);
    issue(1'b0, 1'b1, 8'h02); idle(G);
    issue(1'b0, 1'b1, 8'h08); idle(G);
    issue(1'b0, 1'b1, 8'h20); idle(G);
    issue(1'b0, 1'b1, 8'h80);
    @(negedge clk); #1;
    check("pre_reset_open", {gate_open, occupancy}, {1'b1, 8'h55});
    reset = 1'b1;
    #1;
    check("async_reset", {gate_open, occupancy, free_count, empty, busy},
          {1'b0, 8'h00, 4'd8, 1'b1, 1'b0});
    idle(2);
    reset = 1'b0;
    m_occ = 8'h00; m_slot = 3'd0; open_until = 0;
    idle(3);
    check("scoreboard_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
